// File: rtl/expr_tx_if.sv
// Character-stream bundle between a stimulus source (master) and expr_tx (slave).
interface expr_tx_if #(
    parameter int unsigned MAX_TERMS = 4
);
    logic                   start;
    logic [3:0]             num_terms;
    logic [4*MAX_TERMS-1:0] digits;
    logic [MAX_TERMS-2:0]   ops;
    logic                   term_en;
    logic [7:0]             out;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, num_terms, digits, ops, term_en, out_ready,
        input  out, out_valid, out_last, busy, done, err
    );

    modport slave (
        input  start, num_terms, digits, ops, term_en, out_ready,
        output out, out_valid, out_last, busy, done, err
    );
endinterface

// File: rtl/expr_tx.sv
// Serial ASCII expression generator: emits digit (op digit)* [TERM_CHAR], one char per handshake.
module expr_tx #(
    parameter int unsigned MAX_TERMS = 4,
    parameter logic [7:0]  TERM_CHAR = 8'h3B
) (
    input logic      clk,
    input logic      clr,
    expr_tx_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDigit, StOp, StTerm} state_e;

    localparam logic [3:0] MaxTerms4 = 4'(MAX_TERMS);

    state_e                 r_state, w_state_d;
    logic [4*MAX_TERMS-1:0] r_digits, w_digits_d;
    logic [MAX_TERMS-2:0]   r_ops, w_ops_d;
    logic [3:0]             r_num, w_num_d;
    logic [3:0]             r_k, w_k_d;
    logic                   r_term_en, w_term_en_d;
    logic [7:0]             r_out, w_out_d;
    logic                   r_valid, w_valid_d;
    logic                   r_last, w_last_d;
    logic                   r_busy, w_busy_d;
    logic                   r_done, w_done_d;
    logic                   r_err, w_err_d;

    logic                   w_legal;
    logic                   w_hs;
    logic                   w_finish;
    logic                   w_op_bit;
    logic [3:0]             w_next_dig;

    assign w_hs = r_valid & bus.out_ready;

    // Start legality: operand count in range and every used operand is BCD.
    always_comb begin
        w_legal = (bus.num_terms != 4'd0) && (bus.num_terms <= MaxTerms4);
        for (int unsigned i = 0; i < MAX_TERMS; i++) begin
            if ((4'(i) < bus.num_terms) && (bus.digits[4*i +: 4] > 4'd9)) begin
                w_legal = 1'b0;
            end
        end
    end

    // Select operator k and operand k+1 from the captured set.
    always_comb begin
        w_op_bit   = 1'b0;
        w_next_dig = 4'd0;
        for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
            if (r_k == 4'(i)) begin
                w_op_bit   = r_ops[i];
                w_next_dig = r_digits[4*(i+1) +: 4];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_d   = r_state;
        w_digits_d  = r_digits;
        w_ops_d     = r_ops;
        w_num_d     = r_num;
        w_k_d       = r_k;
        w_term_en_d = r_term_en;
        w_out_d     = r_out;
        w_valid_d   = r_valid;
        w_last_d    = r_last;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;
        w_finish    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (w_legal) begin
                        w_digits_d  = bus.digits;
                        w_ops_d     = bus.ops;
                        w_num_d     = bus.num_terms;
                        w_term_en_d = bus.term_en;
                        w_k_d       = 4'd0;
                        w_out_d     = 8'h30 + {4'h0, bus.digits[3:0]};
                        w_valid_d   = 1'b1;
                        w_busy_d    = 1'b1;
                        w_last_d    = (bus.num_terms == 4'd1) && !bus.term_en;
                        w_state_d   = StDigit;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            StDigit: begin
                if (w_hs) begin
                    if (r_k != r_num - 4'd1) begin
                        w_out_d   = w_op_bit ? 8'h2A : 8'h2B;
                        w_last_d  = 1'b0;
                        w_state_d = StOp;
                    end else if (r_term_en) begin
                        w_out_d   = TERM_CHAR;
                        w_last_d  = 1'b1;
                        w_state_d = StTerm;
                    end else begin
                        w_finish = 1'b1;
                    end
                end
            end
            StOp: begin
                if (w_hs) begin
                    w_k_d     = r_k + 4'd1;
                    w_out_d   = 8'h30 + {4'h0, w_next_dig};
                    // Operand k+1 is final when it is the last term and no terminator follows.
                    w_last_d  = (r_k + 4'd2 == r_num) && !r_term_en;
                    w_state_d = StDigit;
                end
            end
            StTerm: begin
                if (w_hs) w_finish = 1'b1;
            end
            default: w_state_d = StIdle;
        endcase

        if (w_finish) begin
            w_out_d   = 8'h00;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= StIdle;
            r_digits  <= '0;
            r_ops     <= '0;
            r_num     <= 4'd0;
            r_k       <= 4'd0;
            r_term_en <= 1'b0;
            r_out     <= 8'h00;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_digits  <= w_digits_d;
            r_ops     <= w_ops_d;
            r_num     <= w_num_d;
            r_k       <= w_k_d;
            r_term_en <= w_term_en_d;
            r_out     <= w_out_d;
            r_valid   <= w_valid_d;
            r_last    <= w_last_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_expr_tx.sv
// Self-checking bench for expr_tx: vector table, directed corner sequences, random streams.
module tb_expr_tx;
    localparam int unsigned MaxTerms = 4;
    localparam logic [7:0]  TermChar = 8'h3B;

    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    expr_tx_if #(.MAX_TERMS(MaxTerms)) bus ();

    expr_tx #(
        .MAX_TERMS(MaxTerms),
        .TERM_CHAR(TermChar)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  num;
        logic [15:0] dig;
        logic [2:0]  ops;
        bit          term;
        bit          exp_err;
        int          exp_len;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    byte unsigned exp_q[$];
    int          obs_cnt;
    logic [7:0]  obs_first;
    logic [7:0]  obs_last_ch;
    vec_t        vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a start is legal when the count is in range and every used operand is BCD.
    function automatic bit model_legal(input int num, input logic [15:0] dig);
        if (num < 1 || num > int'(MaxTerms)) return 1'b0;
        for (int i = 0; i < num; i++) begin
            if (dig[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: the full character sequence of an expression.
    task automatic model_build(input int num, input logic [15:0] dig, input logic [2:0] ops,
                               input bit term);
        exp_q.delete();
        for (int i = 0; i < num; i++) begin
            exp_q.push_back(8'h30 + 8'(dig[4*i +: 4]));
            if (i < num - 1) exp_q.push_back(ops[i] ? 8'h2A : 8'h2B);
        end
        if (term) exp_q.push_back(TermChar);
    endtask

    task automatic start_expr(input logic [3:0] num, input logic [15:0] dig, input logic [2:0] ops,
                              input bit term);
        bus.num_terms = num;
        bus.digits    = dig;
        bus.ops       = ops;
        bus.term_en   = term;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic check_reject(input string tag);
        check({tag, " err pulse"}, 32'(bus.err), 32'd1);
        check({tag, " no valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " not busy"}, 32'(bus.busy), 32'd0);
        tick();
        check({tag, " err one cycle"}, 32'(bus.err), 32'd0);
        check({tag, " still idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Consume exp_q from the DUT; ends in the cycle where done should be high.
    task automatic stream_check(input string tag, input int stall_pct, input int stall_at,
                                input int stall_len, input bit poke);
        int idx     = 0;
        int cyc     = 0;
        int stalled = 0;
        bit hs;
        obs_cnt     = 0;
        obs_first   = 8'h00;
        obs_last_ch = 8'h00;
        while (idx < exp_q.size() && cyc < 300) begin
            check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " busy"}, 32'(bus.busy), 32'd1);
            check({tag, " char"}, 32'(bus.out), 32'(exp_q[idx]));
            check({tag, " last"}, 32'(bus.out_last), 32'(idx == exp_q.size() - 1));
            check({tag, " no done"}, 32'(bus.done), 32'd0);
            check({tag, " no err"}, 32'(bus.err), 32'd0);
            if (stall_len > 0 && idx == stall_at && stalled < stall_len) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else begin
                bus.out_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
            end
            // A start while busy, carrying different operands, must be ignored.
            if (poke && cyc == 1) begin
                bus.start     = 1'b1;
                bus.digits    = 16'h1111;
                bus.num_terms = 4'd2;
                bus.term_en   = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            hs = bus.out_ready && bus.out_valid;
            if (hs) begin
                if (obs_cnt == 0) obs_first = bus.out;
                obs_last_ch = bus.out;
                obs_cnt++;
            end
            tick();
            cyc++;
            if (hs) idx++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        if (cyc >= 300) check({tag, " stream timeout"}, 32'd1, 32'd0);
        check({tag, " done pulse"}, 32'(bus.done), 32'd1);
        check({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
        check({tag, " out zero"}, 32'(bus.out), 32'd0);
        check({tag, " last clear"}, 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd3, 16'h0705, 3'b010, 1'b1, 1'b0, 6, 8'h35, 8'h3B};
        vecs[1] = '{4'd1, 16'h0009, 3'b000, 1'b0, 1'b0, 1, 8'h39, 8'h39};
        vecs[2] = '{4'd2, 16'h00A3, 3'b000, 1'b0, 1'b1, 0, 8'h00, 8'h00};
        vecs[3] = '{4'd0, 16'h0001, 3'b000, 1'b0, 1'b1, 0, 8'h00, 8'h00};
        vecs[4] = '{4'd1, 16'h00A3, 3'b000, 1'b0, 1'b0, 1, 8'h33, 8'h33};
        vecs[5] = '{4'd4, 16'h9876, 3'b111, 1'b0, 1'b0, 7, 8'h36, 8'h39};
        vecs[6] = '{4'd5, 16'h1234, 3'b000, 1'b1, 1'b1, 0, 8'h00, 8'h00};
        vecs[7] = '{4'd4, 16'hF123, 3'b000, 1'b1, 1'b1, 0, 8'h00, 8'h00};
        vecs[8] = '{4'd2, 16'h0012, 3'b001, 1'b1, 1'b0, 4, 8'h32, 8'h3B};

        bus.start     = 1'b0;
        bus.num_terms = 4'd0;
        bus.digits    = '0;
        bus.ops       = '0;
        bus.term_en   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #3;
        check("reset out", 32'(bus.out), 32'd0);
        check("reset valid", 32'(bus.out_valid), 32'd0);
        check("reset last", 32'(bus.out_last), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        tick();
        clr = 1'b0;
        tick();

        // Vector table, out_ready held high.
        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            model_build(int'(vecs[v].num), vecs[v].dig, vecs[v].ops, vecs[v].term);
            start_expr(vecs[v].num, vecs[v].dig, vecs[v].ops, vecs[v].term);
            if (vecs[v].exp_err) begin
                check_reject(tag);
            end else begin
                check({tag, " no err"}, 32'(bus.err), 32'd0);
                stream_check(tag, 0, -1, 0, 1'b0);
                check({tag, " count"}, 32'(obs_cnt), 32'(vecs[v].exp_len));
                check({tag, " first"}, 32'(obs_first), 32'(vecs[v].exp_first));
                check({tag, " final"}, 32'(obs_last_ch), 32'(vecs[v].exp_last));
                tick();
                check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
            end
        end

        // Backpressure: 3 stall cycles while '+' is presented.
        model_build(3, 16'h0705, 3'b010, 1'b1);
        start_expr(4'd3, 16'h0705, 3'b010, 1'b1);
        stream_check("bp", 0, 1, 3, 1'b0);
        check("bp count", 32'(obs_cnt), 32'd6);
        tick();

        // Asynchronous clear mid-stream, after three characters.
        bus.out_ready = 1'b1;
        start_expr(4'd3, 16'h0705, 3'b010, 1'b1);
        tick();
        tick();
        tick();
        check("pre-clr char", 32'(bus.out), 32'h2A);
        #2 clr = 1'b1;
        #1;
        check("clr out", 32'(bus.out), 32'd0);
        check("clr valid", 32'(bus.out_valid), 32'd0);
        check("clr last", 32'(bus.out_last), 32'd0);
        check("clr busy", 32'(bus.busy), 32'd0);
        check("clr done", 32'(bus.done), 32'd0);
        check("clr err", 32'(bus.err), 32'd0);
        #1 clr = 1'b0;
        tick();
        check("post-clr idle", 32'(bus.out_valid), 32'd0);
        model_build(2, 16'h0048, 3'b000, 1'b0);
        start_expr(4'd2, 16'h0048, 3'b000, 1'b0);
        stream_check("post-clr", 0, -1, 0, 1'b0);
        tick();

        // Start during busy is ignored; start in the done cycle is accepted.
        model_build(3, 16'h0705, 3'b010, 1'b1);
        start_expr(4'd3, 16'h0705, 3'b010, 1'b1);
        stream_check("poke", 20, -1, 0, 1'b1);
        model_build(2, 16'h0021, 3'b001, 1'b1);
        start_expr(4'd2, 16'h0021, 3'b001, 1'b1);
        stream_check("chain", 0, -1, 0, 1'b0);
        tick();

        // Random expressions with random backpressure.
        for (int r = 0; r < 40; r++) begin
            int          num;
            logic [15:0] dig;
            logic [2:0]  ops;
            bit          term;
            string       tag;
            tag  = $sformatf("rnd%0d", r);
            num  = int'($urandom_range(0, 5));
            for (int i = 0; i < 4; i++) dig[4*i +: 4] = 4'($urandom_range(0, 10));
            ops  = 3'($urandom);
            term = 1'($urandom);
            model_build(num, dig, ops, term);
            start_expr(4'(num), dig, ops, term);
            if (!model_legal(num, dig)) begin
                check_reject(tag);
            end else begin
                stream_check(tag, 30, -1, 0, 1'b0);
                check({tag, " count"}, 32'(obs_cnt), 32'(2 * num - 1 + int'(term)));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
